// File: rtl/dmc_pkg.sv
// Shared encodings and read-miss table types for dcache_mem_ctrl.
package dmc_pkg;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam logic [1:0] MEM_BYTE   = 2'd0;
  localparam logic [1:0] MEM_HALF   = 2'd1;
  localparam logic [1:0] MEM_WORD   = 2'd2;
  localparam logic [1:0] MEM_DOUBLE = 2'd3;

  typedef enum logic [1:0] {
    RD_FREE = 2'd0,
    RD_PEND = 2'd1,
    RD_OUT  = 2'd2
  } rd_state_e;

  typedef struct packed {
    rd_state_e   state;
    logic [12:0] blk;
    logic [15:0] gnt;
    logic [3:0]  mem_tag;
  } rd_entry_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
  } wb_entry_t;

endpackage

// File: rtl/dmc_wbuf.sv
// In-order store FIFO: two enqueues per cycle (wb before wr), one pop, block-match lookup.
module dmc_wbuf
  import dmc_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_en,
  input  logic [15:0] wb_addr,
  input  logic [63:0] wb_data,
  input  logic [1:0]  wb_size,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [63:0] wr_data,
  input  logic [1:0]  wr_size,
  input  logic        pop,
  input  logic [12:0] lk_blk,
  output logic        lk_hit,
  output logic [15:0] head_addr,
  output logic [63:0] head_data,
  output logic [1:0]  head_size,
  output logic        empty,
  output logic        full,
  output logic        near_full
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = $clog2(WB_DEPTH + 1);

  wb_entry_t      mem_q [WB_DEPTH];
  wb_entry_t      mem_d [WB_DEPTH];
  logic [PW-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           wb_ok, wr_ok, drop;
  int             free_n;

  always_comb begin
    mem_d  = mem_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    free_n = WB_DEPTH - int'(cnt_q);
    wb_ok  = wb_en && (free_n >= 1);
    wr_ok  = wr_en && (free_n >= (wb_ok ? 2 : 1));
    drop   = (wb_en && !wb_ok) || (wr_en && !wr_ok);
    if (wb_ok) begin
      mem_d[wp_d] = '{addr: wb_addr, data: wb_data, size: wb_size};
      wp_d = wp_d + 1'b1;
    end
    if (wr_ok) begin
      mem_d[wp_d] = '{addr: wr_addr, data: wr_data, size: wr_size};
      wp_d = wp_d + 1'b1;
    end
    if (pop) rp_d = rp_q + 1'b1;
    cnt_d = cnt_q + CW'(wb_ok) + CW'(wr_ok) - CW'(pop);
  end

  // Occupied slots are the cnt_q entries starting at the read pointer.
  always_comb begin
    lk_hit = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (CW'(PW'(i) - rp_q) < cnt_q && mem_q[i].addr[15:3] == lk_blk) lk_hit = 1'b1;
    end
  end

  assign head_addr = mem_q[rp_q].addr;
  assign head_data = mem_q[rp_q].data;
  assign head_size = mem_q[rp_q].size;
  assign empty     = (cnt_q == '0);
  assign full      = (int'(cnt_q) > WB_DEPTH - 2);
  assign near_full = (int'(cnt_q) >= WB_DEPTH - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < WB_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
      assert (!drop);
    end
  end

endmodule

// File: rtl/dcache_mem_ctrl.sv
// Dcache memory controller: store FIFO + read-miss table sharing one memory command port.
// Optional DMC_RD_COALESCE_EN merges reads to an already tracked block into that entry.
module dcache_mem_ctrl
  import dmc_pkg::*;
#(
  parameter int WB_DEPTH = 4,
  parameter int RD_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_en_in,
  input  logic [15:0] wb_addr_in,
  input  logic [63:0] wb_data_in,
  input  logic [1:0]  wb_size_in,
  input  logic        wr_en_in,
  input  logic [15:0] wr_addr_in,
  input  logic [63:0] wr_data_in,
  input  logic [1:0]  wr_size_in,
  input  logic        rd_en_in,
  input  logic [15:0] rd_addr_in,
  input  logic [15:0] rd_gnt_in,
  output logic [1:0]  proc2mem_command,
  output logic [15:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic [1:0]  proc2mem_size,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic        fill_en,
  output logic [4:0]  fill_idx,
  output logic [7:0]  fill_tag,
  output logic [63:0] fill_data,
  output logic [15:0] fill_gnt,
  output logic        wbuf_full,
  output logic        rdq_full
);
  localparam int IW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;

  rd_entry_t       rd_q [RD_DEPTH];
  rd_entry_t       rd_d [RD_DEPTH];
  logic            pend_any, free_any, fill_hit, co_hit;
  logic [IW-1:0]   pend_idx, free_idx, fill_i, co_i;
  logic            sel_store, accept, wb_pop, wb_hit, wb_empty, wb_near;
  logic [15:0]     wb_head_addr;
  logic [63:0]     wb_head_data;
  logic [1:0]      wb_head_size;
  logic            unused_ok;

  assign unused_ok = ^rd_addr_in[2:0];

  dmc_wbuf #(.WB_DEPTH(WB_DEPTH)) u_wbuf (
    .clk(clock), .reset(reset),
    .wb_en(wb_en_in), .wb_addr(wb_addr_in), .wb_data(wb_data_in), .wb_size(wb_size_in),
    .wr_en(wr_en_in), .wr_addr(wr_addr_in), .wr_data(wr_data_in), .wr_size(wr_size_in),
    .pop(wb_pop), .lk_blk(rd_q[pend_idx].blk), .lk_hit(wb_hit),
    .head_addr(wb_head_addr), .head_data(wb_head_data), .head_size(wb_head_size),
    .empty(wb_empty), .full(wbuf_full), .near_full(wb_near)
  );

  // Downward scans leave the lowest matching index in each *_idx.
  always_comb begin
    pend_any = 1'b0; pend_idx = '0;
    free_any = 1'b0; free_idx = '0;
    fill_hit = 1'b0; fill_i   = '0;
    for (int i = RD_DEPTH - 1; i >= 0; i--) begin
      if (rd_q[i].state == RD_PEND) begin pend_any = 1'b1; pend_idx = IW'(i); end
      if (rd_q[i].state == RD_FREE) begin free_any = 1'b1; free_idx = IW'(i); end
      if (rd_q[i].state == RD_OUT && mem2proc_tag != 4'd0 && rd_q[i].mem_tag == mem2proc_tag) begin
        fill_hit = 1'b1; fill_i = IW'(i);
      end
    end
  end

  assign rdq_full  = !free_any;
  assign accept    = (mem2proc_response != 4'd0);
  assign sel_store = !wb_empty && (!pend_any || wb_hit || wb_near);
  assign wb_pop    = sel_store && accept;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    proc2mem_size    = '0;
    if (sel_store) begin
      proc2mem_command = BUS_STORE;
      proc2mem_addr    = wb_head_addr;
      proc2mem_data    = wb_head_data;
      proc2mem_size    = wb_head_size;
    end else if (pend_any) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = {rd_q[pend_idx].blk, 3'b000};
      proc2mem_size    = MEM_DOUBLE;
    end
  end

  assign fill_en   = fill_hit;
  assign fill_idx  = fill_hit ? rd_q[fill_i].blk[4:0]  : '0;
  assign fill_tag  = fill_hit ? rd_q[fill_i].blk[12:5] : '0;
  assign fill_data = fill_hit ? mem2proc_data          : '0;
  assign fill_gnt  = fill_hit ? rd_q[fill_i].gnt       : '0;

  always_comb begin
    rd_d   = rd_q;
    co_hit = 1'b0;
    co_i   = '0;
    if (!sel_store && pend_any && accept) begin
      rd_d[pend_idx].state   = RD_OUT;
      rd_d[pend_idx].mem_tag = mem2proc_response;
    end
    if (fill_hit) rd_d[fill_i] = '0;
`ifdef DMC_RD_COALESCE_EN
    for (int i = RD_DEPTH - 1; i >= 0; i--) begin
      if (rd_q[i].state != RD_FREE && !(fill_hit && fill_i == IW'(i)) &&
          rd_q[i].blk == rd_addr_in[15:3]) begin
        co_hit = 1'b1; co_i = IW'(i);
      end
    end
`endif
    // free_idx comes from registered state, so a slot freed by this cycle's fill is not reused.
    if (rd_en_in) begin
      if (co_hit) begin
        rd_d[co_i].gnt = rd_d[co_i].gnt | rd_gnt_in;
      end else if (free_any) begin
        rd_d[free_idx].state   = RD_PEND;
        rd_d[free_idx].blk     = rd_addr_in[15:3];
        rd_d[free_idx].gnt     = rd_gnt_in;
        rd_d[free_idx].mem_tag = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RD_DEPTH; i++) rd_q[i] <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Directed self-checking bench for dcache_mem_ctrl; expectations adapt to DMC_RD_COALESCE_EN.
module tb_dcache_mem_ctrl;
  import dmc_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_en_in, wr_en_in, rd_en_in;
  logic [15:0] wb_addr_in, wr_addr_in, rd_addr_in, rd_gnt_in;
  logic [63:0] wb_data_in, wr_data_in;
  logic [1:0]  wb_size_in, wr_size_in;
  logic [1:0]  proc2mem_command, proc2mem_size;
  logic [15:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic        fill_en;
  logic [4:0]  fill_idx;
  logic [7:0]  fill_tag;
  logic [63:0] fill_data;
  logic [15:0] fill_gnt;
  logic        wbuf_full, rdq_full;

  int n_chk = 0;
  int n_fail = 0;

  dcache_mem_ctrl dut (
    .clock(clock), .reset(reset),
    .wb_en_in(wb_en_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in), .wb_size_in(wb_size_in),
    .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in), .wr_size_in(wr_size_in),
    .rd_en_in(rd_en_in), .rd_addr_in(rd_addr_in), .rd_gnt_in(rd_gnt_in),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .fill_en(fill_en), .fill_idx(fill_idx), .fill_tag(fill_tag), .fill_data(fill_data),
    .fill_gnt(fill_gnt), .wbuf_full(wbuf_full), .rdq_full(rdq_full)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wb_en_in = 0; wb_addr_in = 0; wb_data_in = 0; wb_size_in = 0;
    wr_en_in = 0; wr_addr_in = 0; wr_data_in = 0; wr_size_in = 0;
    rd_en_in = 0; rd_addr_in = 0; rd_gnt_in = 0;
    mem2proc_response = 0; mem2proc_data = 0; mem2proc_tag = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1; tick(); tick();
    reset = 0; #1;
    n_chk++; if (proc2mem_command !== BUS_NONE) begin n_fail++; $display("FAIL rst_cmd got %0d exp %0d", proc2mem_command, BUS_NONE); end
    n_chk++; if (proc2mem_addr !== 16'h0 || proc2mem_data !== 64'h0 || proc2mem_size !== 2'd0) begin n_fail++; $display("FAIL rst_payload got %h/%h/%0d exp 0", proc2mem_addr, proc2mem_data, proc2mem_size); end
    n_chk++; if (fill_en !== 1'b0 || fill_gnt !== 16'h0 || fill_data !== 64'h0) begin n_fail++; $display("FAIL rst_fill got %b/%h/%h exp 0", fill_en, fill_gnt, fill_data); end
    n_chk++; if (wbuf_full !== 1'b0 || rdq_full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b/%b exp 0/0", wbuf_full, rdq_full); end
  endtask

  task automatic test_store();
    wr_en_in = 1; wr_addr_in = 16'h1238; wr_data_in = 64'hAB; wr_size_in = MEM_BYTE;
    tick(); idle();
    n_chk++; if (proc2mem_command !== BUS_STORE) begin n_fail++; $display("FAIL st_cmd got %0d exp %0d", proc2mem_command, BUS_STORE); end
    n_chk++; if (proc2mem_addr !== 16'h1238 || proc2mem_data !== 64'hAB || proc2mem_size !== MEM_BYTE) begin n_fail++; $display("FAIL st_payload got %h/%h/%0d exp 1238/ab/0", proc2mem_addr, proc2mem_data, proc2mem_size); end
    mem2proc_response = 3; tick(); idle();
    n_chk++; if (proc2mem_command !== BUS_NONE) begin n_fail++; $display("FAIL st_empty got %0d exp %0d", proc2mem_command, BUS_NONE); end
  endtask

  task automatic test_load();
    rd_en_in = 1; rd_addr_in = 16'h0400; rd_gnt_in = 16'h0004;
    tick(); idle();
    n_chk++; if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 16'h0400 || proc2mem_size !== MEM_DOUBLE) begin n_fail++; $display("FAIL ld_cmd got %0d/%h/%0d exp 1/0400/3", proc2mem_command, proc2mem_addr, proc2mem_size); end
    mem2proc_response = 5; tick(); idle();
    n_chk++; if (proc2mem_command !== BUS_NONE) begin n_fail++; $display("FAIL ld_out got %0d exp 0", proc2mem_command); end
    mem2proc_tag = 5; mem2proc_data = 64'hDEAD; #1;
    n_chk++; if (fill_en !== 1'b1 || fill_idx !== 5'd0 || fill_tag !== 8'h04) begin n_fail++; $display("FAIL ld_fill got en %b idx %h tag %h exp 1/00/04", fill_en, fill_idx, fill_tag); end
    n_chk++; if (fill_gnt !== 16'h0004 || fill_data !== 64'hDEAD) begin n_fail++; $display("FAIL ld_fill_data got %h/%h exp 0004/dead", fill_gnt, fill_data); end
    tick(); #1;
    n_chk++; if (fill_en !== 1'b0 || fill_data !== 64'h0) begin n_fail++; $display("FAIL ld_stale_tag got %b/%h exp 0/0", fill_en, fill_data); end
    idle();
  endtask

  task automatic test_order();
    wr_en_in = 1; wr_addr_in = 16'h0408; wr_data_in = 64'h55; wr_size_in = MEM_DOUBLE;
    tick(); idle();
    rd_en_in = 1; rd_addr_in = 16'h0408; rd_gnt_in = 16'h0001;
    tick(); idle();
    n_chk++; if (proc2mem_command !== BUS_STORE || proc2mem_addr !== 16'h0408) begin n_fail++; $display("FAIL ord_store got %0d/%h exp 2/0408", proc2mem_command, proc2mem_addr); end
    mem2proc_response = 1; tick(); idle();
    n_chk++; if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 16'h0408) begin n_fail++; $display("FAIL ord_load got %0d/%h exp 1/0408", proc2mem_command, proc2mem_addr); end
    mem2proc_response = 2; tick(); idle();
    mem2proc_tag = 2; #1;
    n_chk++; if (fill_en !== 1'b1 || fill_gnt !== 16'h0001 || fill_idx !== 5'h01) begin n_fail++; $display("FAIL ord_fill got %b/%h/%h exp 1/0001/01", fill_en, fill_gnt, fill_idx); end
    tick(); idle();
    // Non-matching store with a pending read: load wins.
    wr_en_in = 1; wr_addr_in = 16'h2000; wr_data_in = 64'h77; wr_size_in = MEM_WORD;
    rd_en_in = 1; rd_addr_in = 16'h3000; rd_gnt_in = 16'h0100;
    tick(); idle();
    n_chk++; if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 16'h3000) begin n_fail++; $display("FAIL prio_load got %0d/%h exp 1/3000", proc2mem_command, proc2mem_addr); end
    mem2proc_response = 4; tick(); idle();
    n_chk++; if (proc2mem_command !== BUS_STORE || proc2mem_addr !== 16'h2000 || proc2mem_size !== MEM_WORD) begin n_fail++; $display("FAIL prio_store got %0d/%h/%0d exp 2/2000/2", proc2mem_command, proc2mem_addr, proc2mem_size); end
    mem2proc_response = 1; mem2proc_tag = 4; #1;
    n_chk++; if (fill_en !== 1'b1 || fill_tag !== 8'h30 || fill_gnt !== 16'h0100) begin n_fail++; $display("FAIL prio_fill got %b/%h/%h exp 1/30/0100", fill_en, fill_tag, fill_gnt); end
    tick(); idle();
    n_chk++; if (proc2mem_command !== BUS_NONE) begin n_fail++; $display("FAIL prio_done got %0d exp 0", proc2mem_command); end
  endtask

  task automatic test_stall();
    wr_en_in = 1; wr_addr_in = 16'h0010; wr_data_in = 64'h1111; wr_size_in = MEM_WORD;
    tick(); idle();
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (proc2mem_command !== BUS_STORE || proc2mem_addr !== 16'h0010 || proc2mem_data !== 64'h1111) begin n_fail++; $display("FAIL stall_hold c%0d got %0d/%h/%h exp 2/0010/1111", c, proc2mem_command, proc2mem_addr, proc2mem_data); end
      tick();
    end
    mem2proc_response = 1; tick(); idle();
    n_chk++; if (proc2mem_command !== BUS_NONE) begin n_fail++; $display("FAIL stall_done got %0d exp 0", proc2mem_command); end
  endtask

  task automatic test_wbuf_full();
    wb_en_in = 1; wb_addr_in = 16'h0100; wb_data_in = 64'h1; wb_size_in = MEM_DOUBLE;
    wr_en_in = 1; wr_addr_in = 16'h0108; wr_data_in = 64'h2; wr_size_in = MEM_DOUBLE;
    tick(); idle();
    n_chk++; if (wbuf_full !== 1'b0 || proc2mem_addr !== 16'h0100) begin n_fail++; $display("FAIL wb_dual got full %b addr %h exp 0/0100", wbuf_full, proc2mem_addr); end
    wb_en_in = 1; wb_addr_in = 16'h0110; wb_data_in = 64'h3; wb_size_in = MEM_DOUBLE;
    tick(); idle();
    n_chk++; if (wbuf_full !== 1'b1) begin n_fail++; $display("FAIL wb_full got %b exp 1", wbuf_full); end
    mem2proc_response = 1; tick();
    n_chk++; if (wbuf_full !== 1'b0 || proc2mem_addr !== 16'h0108 || proc2mem_data !== 64'h2) begin n_fail++; $display("FAIL wb_pop1 got %b/%h/%h exp 0/0108/2", wbuf_full, proc2mem_addr, proc2mem_data); end
    tick();
    n_chk++; if (proc2mem_addr !== 16'h0110) begin n_fail++; $display("FAIL wb_pop2 got %h exp 0110", proc2mem_addr); end
    tick(); idle();
    n_chk++; if (proc2mem_command !== BUS_NONE) begin n_fail++; $display("FAIL wb_drain got %0d exp 0", proc2mem_command); end
  endtask

  task automatic test_rdq_full();
    logic [15:0] exp_gnt;
    for (int i = 0; i < 4; i++) begin
      rd_en_in = 1; rd_addr_in = 16'h0800 + 16'(i * 16); rd_gnt_in = 16'(1 << i);
      tick();
    end
    idle();
    n_chk++; if (rdq_full !== 1'b1 || proc2mem_addr !== 16'h0800) begin n_fail++; $display("FAIL rq_full got %b/%h exp 1/0800", rdq_full, proc2mem_addr); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 16'h0800 + 16'(i * 16)) begin n_fail++; $display("FAIL rq_issue%0d got %0d/%h exp 1/%h", i, proc2mem_command, proc2mem_addr, 16'h0800 + 16'(i * 16)); end
      mem2proc_response = 4'(6 + i); tick();
    end
    idle();
    n_chk++; if (rdq_full !== 1'b1 || proc2mem_command !== BUS_NONE) begin n_fail++; $display("FAIL rq_allout got %b/%0d exp 1/0", rdq_full, proc2mem_command); end
    mem2proc_tag = 4'hF; #1;
    n_chk++; if (fill_en !== 1'b0) begin n_fail++; $display("FAIL rq_badtag got %b exp 0", fill_en); end
    idle();
    rd_en_in = 1; rd_addr_in = 16'h0810; rd_gnt_in = 16'h0010;
    tick(); idle();
`ifdef DMC_RD_COALESCE_EN
    exp_gnt = 16'h0012;
`else
    exp_gnt = 16'h0002;
`endif
    // Fill frees entry 1 while a new read arrives; the freed slot must not be taken.
    mem2proc_tag = 7; mem2proc_data = 64'hBEEF;
    rd_en_in = 1; rd_addr_in = 16'h0900; rd_gnt_in = 16'h0001; #1;
    n_chk++; if (fill_en !== 1'b1 || fill_idx !== 5'h02 || fill_tag !== 8'h08) begin n_fail++; $display("FAIL rq_fill got %b/%h/%h exp 1/02/08", fill_en, fill_idx, fill_tag); end
    n_chk++; if (fill_gnt !== exp_gnt) begin n_fail++; $display("FAIL rq_gnt got %h exp %h", fill_gnt, exp_gnt); end
    tick(); idle();
    n_chk++; if (rdq_full !== 1'b0 || proc2mem_command !== BUS_NONE) begin n_fail++; $display("FAIL rq_noalloc got %b/%0d exp 0/0", rdq_full, proc2mem_command); end
  endtask

  task automatic test_reset_mid();
    reset = 1; tick();
    reset = 0; #1;
    mem2proc_tag = 6; #1;
    n_chk++; if (fill_en !== 1'b0 || fill_gnt !== 16'h0) begin n_fail++; $display("FAIL rm_tag6 got %b/%h exp 0/0", fill_en, fill_gnt); end
    mem2proc_tag = 8; #1;
    n_chk++; if (fill_en !== 1'b0) begin n_fail++; $display("FAIL rm_tag8 got %b exp 0", fill_en); end
    n_chk++; if (rdq_full !== 1'b0 || proc2mem_command !== BUS_NONE) begin n_fail++; $display("FAIL rm_state got %b/%0d exp 0/0", rdq_full, proc2mem_command); end
    idle(); tick();
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_order();
    test_stall();
    test_wbuf_full();
    test_rdq_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
